spi_reg_slave: RTL
==================

Name: spi_reg_slave

Overview:
- SPI slave front end of the system board. Deserialises host frames arriving on the qspix10 pins and drives the internal register bus: per-slot output, input, direction, interrupt, mask and clear registers, plus the SPI-master control registers.
- Frame format, MSB first, mode 0: 1 R/~W bit, ADDR_W address bits, DUMMY_CYCLES idle clocks, DATA_W data bits.
- SPI inputs are oversampled in the sys_clk domain; all bus outputs are synchronous to sys_clk.

Parameters:
- ADDR_W, 7, register address width
- DATA_W, 16, register data width
- DUMMY_CYCLES, 10, SCK periods between the last address bit and the first data bit
- SYNC_STAGES, 2, synchroniser depth on spi_clk, spi_mosi and spi_cs_n

Ports:
- sys_clk  in  1  system clock; SCK must be at most sys_clk/4
- sys_rst  in  1  synchronous active-high reset
- spi_clk  in  1  host SCK, idle low
- spi_mosi  in  1  host data
- spi_cs_n  in  1  host chip select, active low
- spi_miso  out  1  slave data
- bus_addr  out  ADDR_W  register address
- bus_we  out  1  one-cycle write strobe
- bus_wdata  out  DATA_W  write data, valid with bus_we
- bus_re  out  1  one-cycle read request
- bus_rdata  in  DATA_W  read data
- bus_rvalid  in  1  bus_rdata valid, at most DUMMY_CYCLES*2 sys_clk after bus_re
- frame_err  out  1  one-cycle pulse on an aborted or late-data frame

Behaviour:
- Reset values: spi_miso=0, bus_addr=0, bus_we=0, bus_wdata=0, bus_re=0, frame_err=0, state=IDLE, counters=0. Reset mid-frame discards the frame and issues no strobe.
- Edge detection: after SYNC_STAGES flops, rise/fall are decoded from the synchronised SCK, gated with synchronised cs_n low. Latency from pin to edge pulse is SYNC_STAGES+1 cycles.
- FSM states: IDLE, CMD, ADDR, DUMMY, DATA, WAIT_CS.
  - IDLE -> CMD on synchronised cs_n falling.
  - CMD: capture the R/~W bit on the first rise -> ADDR.
  - ADDR: shift ADDR_W bits on rises. After the last bit, bus_addr is loaded. If the frame is a read, bus_re pulses the cycle after that load. Then -> DUMMY.
  - DUMMY: count DUMMY_CYCLES rises -> DATA.
  - DATA: shift DATA_W bits on rises. After the last bit, for a write, bus_wdata is loaded and bus_we pulses 1 cycle later. Then -> WAIT_CS.
  - WAIT_CS -> IDLE on cs_n high.
- Read data path: bus_rvalid latches bus_rdata into a shift register; bus_rvalid is ignored outside DUMMY. The MSB is driven on spi_miso from the cycle after the latch. On each SCK fall in DATA, the register shifts left and spi_miso takes the next bit.
- Late read data: if bus_rvalid has not arrived by DUMMY exit, spi_miso=0 for the whole data phase, frame_err pulses at DUMMY exit, and later bus_rvalid is ignored.
- For a write frame, spi_miso=0 throughout.
- cs_n high before WAIT_CS: return to IDLE, no bus_we, frame_err pulses once. A bus_re already issued is not retracted.
- Extra SCK rises in WAIT_CS are ignored. spi_miso holds 0 in WAIT_CS and IDLE.
- Simultaneous cs_n rise and the last data rise: the data bit counts and the write completes. The cs_n rise takes effect after the shift.
- The counters are sized for max(ADDR_W, DUMMY_CYCLES, DATA_W) and never wrap inside a state.

Decomposition:
- Shared package spi_reg_pkg holds:
  - the state enum;
  - frame constants ADDR_W, DATA_W, DUMMY_CYCLES;
  - the register-block offsets used by bench and top: OUT=0, IN=1, DIR=2, INT=3, MASK=4, CLR=5, each ×slots_num, and SPI master base (slot+1)×6.
- One sub-module, spi_sync_edge: an N-stage synchroniser plus rise/fall pulse generation. It is instantiated for SCK; mosi and cs_n use the synchroniser only.

Test Plan:
- Write addr 0x00 data 0xAAAA -> exactly one bus_we with bus_addr=0x00, bus_wdata=0xAAAA; bus_re never asserted.
- Read addr 0x0D, bench returns 0x0001 with bus_rvalid 3 cycles after bus_re -> bus_re pulses once with bus_addr=0x0D; host samples 0x0001 on spi_miso; frame_err=0.
- Back-to-back write 0x5555 then read at addr 0x00, with model register feedback -> readback 0x5555; repeat for 0x0000, 0x0001, 0x8000, 0xFFFF, 0x2A2A.
- Write frame with cs_n raised after 8 data bits -> no bus_we, one frame_err pulse; a following full write of 0x1234 to 0x03 completes normally.
- Read where bus_rvalid never arrives -> host samples 0x0000, one frame_err pulse at DUMMY exit.
- sys_rst asserted mid-ADDR, then deasserted while cs_n is still low -> no strobes. FSM stays in IDLE until cs_n toggles high then low, and the next frame succeeds.

Source files
------------

// File: rtl/spi_reg_pkg.sv
// Shared frame constants, FSM state type and register-block map for the SPI
// register slave and its users.
package spi_reg_pkg;

  localparam int ADDR_W       = 7;
  localparam int DATA_W       = 16;
  localparam int DUMMY_CYCLES = 10;

  localparam int CNT_MAX = (ADDR_W > DUMMY_CYCLES) ?
                           ((ADDR_W > DATA_W) ? ADDR_W : DATA_W) :
                           ((DUMMY_CYCLES > DATA_W) ? DUMMY_CYCLES : DATA_W);
  localparam int CNT_W   = $clog2(CNT_MAX + 1);

  // Register block: each kind occupies SLOTS_NUM consecutive addresses.
  localparam int SLOTS_NUM    = 2;
  localparam int REG_OUT      = 0 * SLOTS_NUM;
  localparam int REG_IN       = 1 * SLOTS_NUM;
  localparam int REG_DIR      = 2 * SLOTS_NUM;
  localparam int REG_INT      = 3 * SLOTS_NUM;
  localparam int REG_MASK     = 4 * SLOTS_NUM;
  localparam int REG_CLR      = 5 * SLOTS_NUM;
  localparam int SPI_MST_BASE = (SLOTS_NUM + 1) * 6;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_CMD,
    ST_ADDR,
    ST_DUMMY,
    ST_DATA,
    ST_WAIT_CS
  } state_e;

  function automatic int unsigned reg_addr(input int unsigned kind, input int unsigned slot);
    return kind * SLOTS_NUM + slot;
  endfunction

endpackage

// File: rtl/spi_reg_slave_if.sv
// SPI pin and register-bus signal bundle between the host side and the slave.
interface spi_reg_slave_if;
  import spi_reg_pkg::*;

  // bus_we / bus_re are one-cycle strobes with no backpressure; the bus answers
  // a bus_re with a single-cycle bus_rvalid carrying bus_rdata.
  logic              spi_clk;
  logic              spi_mosi;
  logic              spi_cs_n;
  logic              spi_miso;
  logic [ADDR_W-1:0] bus_addr;
  logic              bus_we;
  logic [DATA_W-1:0] bus_wdata;
  logic              bus_re;
  logic [DATA_W-1:0] bus_rdata;
  logic              bus_rvalid;
  logic              frame_err;

  modport slave (
    input  spi_clk, spi_mosi, spi_cs_n, bus_rdata, bus_rvalid,
    output spi_miso, bus_addr, bus_we, bus_wdata, bus_re, frame_err
  );

  modport master (
    output spi_clk, spi_mosi, spi_cs_n, bus_rdata, bus_rvalid,
    input  spi_miso, bus_addr, bus_we, bus_wdata, bus_re, frame_err
  );

endinterface

// File: rtl/spi_sync_edge.sv
// N-stage synchroniser with registered rise/fall pulses; pin-to-pulse latency
// is STAGES+1 cycles. STAGES must be at least 2.
module spi_sync_edge #(
  parameter int STAGES = 2
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic d_i,
  output logic rise_o,
  output logic fall_o
);

  logic [STAGES-1:0] sync_q;
  logic              prev_q;
  logic              rise_q;
  logic              fall_q;

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      sync_q <= '0;
      prev_q <= 1'b0;
      rise_q <= 1'b0;
      fall_q <= 1'b0;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      prev_q <= sync_q[STAGES-1];
      rise_q <= sync_q[STAGES-1] & ~prev_q;
      fall_q <= ~sync_q[STAGES-1] & prev_q;
    end
  end

  assign rise_o = rise_q;
  assign fall_o = fall_q;

endmodule

// File: rtl/spi_reg_slave.sv
// SPI mode-0 slave that turns host frames (R/~W, address, dummy, data) into
// single-cycle register bus strobes and serves read data back on MISO.
module spi_reg_slave
  import spi_reg_pkg::*;
#(
  parameter int SYNC_STAGES = 2
) (
  input  logic           sys_clk,
  input  logic           sys_rst,
  spi_reg_slave_if.slave bus,
  output state_e         dbg_state_o
);

  logic [SYNC_STAGES-1:0] mosi_sync_q, cs_sync_q;
  logic                   cs_al_q, cs_prev_q;
  logic                   sck_rise_raw, sck_fall_raw;
  logic                   sck_rise, sck_fall, cs_fall, mosi;
  state_e                 state_q, state_d;
  logic [CNT_W-1:0]       cnt_q;
  logic                   rd_q, rd_have_q;
  logic [DATA_W-1:0]      sr_q, rd_sr_q, wdata_q;
  logic [ADDR_W-1:0]      addr_q;
  logic                   miso_q, re_arm_q, re_q, we_arm_q, we_q, err_q;
  logic                   in_frame, abort, addr_done, dummy_done, data_done, err_d;

  spi_sync_edge #(.STAGES(SYNC_STAGES)) u_sck_edge (
    .clk_i  (sys_clk),
    .rst_i  (sys_rst),
    .d_i    (bus.spi_clk),
    .rise_o (sck_rise_raw),
    .fall_o (sck_fall_raw)
  );

  // cs_al_q lines cs_n up with the SCK pulses; edges are gated by the previous
  // cs value so a last data rise coinciding with cs_n rising still counts.
  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      mosi_sync_q <= '0;
      cs_sync_q   <= '0;
      cs_al_q     <= 1'b0;
      cs_prev_q   <= 1'b0;
    end else begin
      mosi_sync_q <= {mosi_sync_q[SYNC_STAGES-2:0], bus.spi_mosi};
      cs_sync_q   <= {cs_sync_q[SYNC_STAGES-2:0], bus.spi_cs_n};
      cs_al_q     <= cs_sync_q[SYNC_STAGES-1];
      cs_prev_q   <= cs_al_q;
    end
  end

  assign mosi     = mosi_sync_q[SYNC_STAGES-1];
  assign sck_rise = sck_rise_raw & ~cs_prev_q;
  assign sck_fall = sck_fall_raw & ~cs_prev_q;
  assign cs_fall  = cs_prev_q & ~cs_al_q;

  always_ff @(posedge sys_clk) begin
    if (sys_rst) state_q <= ST_IDLE;
    else         state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      ST_IDLE:    if (cs_fall) state_d = ST_CMD;
      ST_CMD:     if (cs_al_q) state_d = ST_IDLE;
                  else if (sck_rise) state_d = ST_ADDR;
      ST_ADDR:    if (cs_al_q) state_d = ST_IDLE;
                  else if (sck_rise && cnt_q == CNT_W'(ADDR_W - 1)) state_d = ST_DUMMY;
      ST_DUMMY:   if (cs_al_q) state_d = ST_IDLE;
                  else if (sck_rise && cnt_q == CNT_W'(DUMMY_CYCLES - 1)) state_d = ST_DATA;
      ST_DATA:    if (sck_rise && cnt_q == CNT_W'(DATA_W - 1)) state_d = ST_WAIT_CS;
                  else if (cs_al_q) state_d = ST_IDLE;
      ST_WAIT_CS: if (cs_al_q) state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    in_frame   = (state_q == ST_CMD) || (state_q == ST_ADDR) ||
                 (state_q == ST_DUMMY) || (state_q == ST_DATA);
    abort      = in_frame && (state_d == ST_IDLE);
    addr_done  = (state_q == ST_ADDR) && (state_d == ST_DUMMY);
    dummy_done = (state_q == ST_DUMMY) && (state_d == ST_DATA);
    data_done  = (state_q == ST_DATA) && (state_d == ST_WAIT_CS);
    err_d      = abort || (dummy_done && rd_q && !rd_have_q);
  end

  always_ff @(posedge sys_clk) begin
    if (sys_rst) begin
      cnt_q     <= '0;
      rd_q      <= 1'b0;
      rd_have_q <= 1'b0;
      sr_q      <= '0;
      rd_sr_q   <= '0;
      wdata_q   <= '0;
      addr_q    <= '0;
      miso_q    <= 1'b0;
      re_arm_q  <= 1'b0;
      re_q      <= 1'b0;
      we_arm_q  <= 1'b0;
      we_q      <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      re_arm_q <= addr_done & rd_q;
      re_q     <= re_arm_q;
      we_arm_q <= data_done & ~rd_q;
      we_q     <= we_arm_q;
      err_q    <= err_d;

      if (state_q != state_d) cnt_q <= '0;
      else if (sck_rise && in_frame && state_q != ST_CMD) cnt_q <= cnt_q + CNT_W'(1);

      if (state_q == ST_IDLE && state_d == ST_CMD) begin
        rd_q      <= 1'b0;
        rd_have_q <= 1'b0;
        sr_q      <= '0;
        rd_sr_q   <= '0;
      end
      if (state_q == ST_CMD && sck_rise) rd_q <= mosi;
      if ((state_q == ST_ADDR || state_q == ST_DATA) && sck_rise)
        sr_q <= {sr_q[DATA_W-2:0], mosi};
      if (addr_done) addr_q <= {sr_q[ADDR_W-2:0], mosi};
      if (data_done && !rd_q) wdata_q <= {sr_q[DATA_W-2:0], mosi};

      // Read data is accepted only while still counting dummy clocks.
      if (state_q == ST_DUMMY && state_d == ST_DUMMY && rd_q && !rd_have_q && bus.bus_rvalid) begin
        rd_sr_q   <= bus.bus_rdata;
        miso_q    <= bus.bus_rdata[DATA_W-1];
        rd_have_q <= 1'b1;
      end
      if (state_q == ST_DATA && sck_fall && cnt_q != '0) begin
        rd_sr_q <= {rd_sr_q[DATA_W-2:0], 1'b0};
        miso_q  <= rd_sr_q[DATA_W-2];
      end
      if (state_d == ST_WAIT_CS || state_d == ST_IDLE) miso_q <= 1'b0;
    end
  end

  assign bus.spi_miso  = miso_q;
  assign bus.bus_addr  = addr_q;
  assign bus.bus_we    = we_q;
  assign bus.bus_wdata = wdata_q;
  assign bus.bus_re    = re_q;
  assign bus.frame_err = err_q;
  assign dbg_state_o   = state_q;

endmodule
